mem_arbiter: RTL

//  Shares one single-port RAM between the instruction-fetch requester and the data-access requester.
//  It sits between the datapath (request strobes from the control unit and request unit) and main memory.
//  A registered FSM grants one access at a time, with data priority over fetch, and returns a one-cycle hit and load data.
//  It honours the control unit's halt: outstanding stores drain, then fetching stops until reset.

---
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the instruction-fetch and
// data-access requesters. One access at a time, data over fetch, with a
// registered one-cycle hit and load data. A halt seen in IDLE (after any data
// request has been served) parks the arbiter until reset.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   When defined, an access that waits TIMEOUT_CYCLES cycles without ram_ready
//   is aborted and answered with load=0 and err=1 alongside the hit.
//   When undefined, accesses wait indefinitely and err is tied to 0.
//
// Ports:
//   CLK, RST                        clock (rising edge), synchronous active-high reset
//   iren, iaddr / ihit, iload       instruction fetch request / one-cycle completion + word
//   dren, dwen, daddr, dstore       data read / write request, address, store data
//   dhit, dload                     one-cycle data completion + loaded word (0 for writes)
//   halt / halted                   halt level from control unit / sticky stopped flag
//   ram_ren, ram_wen, ram_addr,
//   ram_store                       registered RAM strobes, address, write data
//   ram_load, ram_ready             RAM read data and one-cycle completion pulse
//   err                             timeout flag, pulses with the hit
module mem_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iren,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   input  logic              dren,
   input  logic              dwen,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   input  logic              halt,
   output logic              halted,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_store,
   input  logic [DATA_W-1:0] ram_load,
   input  logic              ram_ready,
   output logic              err
);

   typedef enum logic [2:0] {
      StIdle,
      StIfetch,
      StDread,
      StDwrite,
      StResp,
      StHalted
   } state_e;

   state_e            state_q, state_d;
   logic              ram_ren_q, ram_ren_d;
   logic              ram_wen_q, ram_wen_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_store_q, ram_store_d;
   logic              ihit_q, ihit_d;
   logic              dhit_q, dhit_d;
   logic [DATA_W-1:0] iload_q, iload_d;
   logic [DATA_W-1:0] dload_q, dload_d;
   logic              halted_q, halted_d;
   logic              timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;

   // cnt_q counts completed waiting cycles; this is the last one allowed.
   assign timeout_hit = !ram_ready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign err         = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
   assign err                = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ram_ren_d   = ram_ren_q;
      ram_wen_d   = ram_wen_q;
      ram_addr_d  = ram_addr_q;
      ram_store_d = ram_store_q;
      ihit_d      = 1'b0;
      dhit_d      = 1'b0;
      iload_d     = '0;
      dload_d     = '0;
      halted_d    = halted_q;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d       = '0;
      err_d       = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            // Data first, then halt, so outstanding loads/stores drain before stopping.
            if (dwen) begin
               state_d     = StDwrite;
               ram_wen_d   = 1'b1;
               ram_addr_d  = daddr;
               ram_store_d = dstore;
            end else if (dren) begin
               state_d    = StDread;
               ram_ren_d  = 1'b1;
               ram_addr_d = daddr;
            end else if (halt) begin
               state_d  = StHalted;
               halted_d = 1'b1;
            end else if (iren) begin
               state_d    = StIfetch;
               ram_ren_d  = 1'b1;
               ram_addr_d = iaddr;
            end
         end
         StIfetch, StDread, StDwrite: begin
            if (ram_ready || timeout_hit) begin
               state_d   = StResp;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               ihit_d    = (state_q == StIfetch);
               dhit_d    = (state_q != StIfetch);
               if (ram_ready) begin
                  if (state_q == StIfetch) iload_d = ram_load;
                  if (state_q == StDread)  dload_d = ram_load;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               err_d = !ram_ready;
`endif
            end else begin
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d = cnt_q + CntW'(1);
`endif
            end
         end
         StResp:   state_d = StIdle;
         StHalted: state_d = StHalted;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_store_q <= '0;
         ihit_q      <= 1'b0;
         dhit_q      <= 1'b0;
         iload_q     <= '0;
         dload_q     <= '0;
         halted_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ram_ren_q   <= ram_ren_d;
         ram_wen_q   <= ram_wen_d;
         ram_addr_q  <= ram_addr_d;
         ram_store_q <= ram_store_d;
         ihit_q      <= ihit_d;
         dhit_q      <= dhit_d;
         iload_q     <= iload_d;
         dload_q     <= dload_d;
         halted_q    <= halted_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign ram_ren   = ram_ren_q;
   assign ram_wen   = ram_wen_q;
   assign ram_addr  = ram_addr_q;
   assign ram_store = ram_store_q;
   assign ihit      = ihit_q;
   assign dhit      = dhit_q;
   assign iload     = iload_q;
   assign dload     = dload_q;
   assign halted    = halted_q;

endmodule
